// File: rtl/chorus_lfo.sv
// Triangle LFO that produces the chorus extra read delay, advancing once per sample strobe.
// Optional build macro LFO_SMOOTH_EN limits the per-strobe output change to SLEW_MAX while running.
module chorus_lfo #(
    parameter int PHASE_WIDTH = 20,
    parameter int TRI_WIDTH   = 10,
    parameter int DEPTH_WIDTH = 10,
    parameter int ADDR_WIDTH  = 13,
    parameter int SLEW_MAX    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid_i,
    input  logic                   en_i,
    input  logic [PHASE_WIDTH-1:0] rate_i,
    input  logic [DEPTH_WIDTH-1:0] depth_i,
    output logic [ADDR_WIDTH-1:0]  extra_delay_o,
    output logic                   running_o
);

    localparam int PROD_W = TRI_WIDTH + DEPTH_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    if (TRI_WIDTH > PHASE_WIDTH - 1) begin : g_bad_tri
        $error("chorus_lfo: TRI_WIDTH must not exceed PHASE_WIDTH-1");
    end
    if (DEPTH_WIDTH > ADDR_WIDTH) begin : g_bad_depth
        $error("chorus_lfo: DEPTH_WIDTH must not exceed ADDR_WIDTH");
    end
    if (SLEW_MAX < 1) begin : g_bad_slew
        $error("chorus_lfo: SLEW_MAX must be at least 1");
    end

    logic [1:0]             state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] rate_q, rate_d;
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic                   run_upd_q, run_upd_d;
    logic                   dec_upd_q, dec_upd_d;
    logic [ADDR_WIDTH-1:0]  out_q, out_d;
    logic                   running_q, running_d;

    // Stage 2: triangle shaping and depth scaling from the registered phase.
    logic [TRI_WIDTH-1:0]   tri_t;
    logic [TRI_WIDTH-1:0]   tri_v;
    logic [PROD_W-1:0]      prod;
    logic [DEPTH_WIDTH-1:0] target_dw;
    logic [TRI_WIDTH-1:0]   prod_lsb_unused;
    logic [ADDR_WIDTH-1:0]  target;
    logic [ADDR_WIDTH-1:0]  run_val;
    logic [ADDR_WIDTH-1:0]  dec_val;

    assign tri_t  = phase_q[PHASE_WIDTH-2 -: TRI_WIDTH];
    assign tri_v  = phase_q[PHASE_WIDTH-1] ? ~tri_t : tri_t;
    assign prod   = PROD_W'(tri_v) * PROD_W'(depth_q);
    assign {target_dw, prod_lsb_unused} = prod;
    assign target = ADDR_WIDTH'(target_dw);

`ifdef LFO_SMOOTH_EN
    localparam logic [ADDR_WIDTH-1:0] SLEW = ADDR_WIDTH'(SLEW_MAX);
    logic [ADDR_WIDTH-1:0] diff;

    always_comb begin
        diff    = '0;
        run_val = target;
        if (target > out_q) begin
            diff    = target - out_q;
            run_val = out_q + ((diff > SLEW) ? SLEW : diff);
        end else if (target < out_q) begin
            diff    = out_q - target;
            run_val = out_q - ((diff > SLEW) ? SLEW : diff);
        end
    end
`else
    assign run_val = target;
`endif

    assign dec_val = (out_q == '0) ? '0 : out_q - ADDR_WIDTH'(1);

    // out_d is the value the output holds once any in-flight update lands;
    // the drain decision looks at it so back-to-back strobes stay exact.
    always_comb begin
        out_d = out_q;
        if (run_upd_q) begin
            out_d = run_val;
        end else if (dec_upd_q) begin
            out_d = dec_val;
        end
    end

    // Stage 1: state machine, phase accumulator and parameter latches.
    logic [PHASE_WIDTH:0] phase_sum;
    assign phase_sum = {1'b0, phase_q} + {1'b0, rate_q};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        rate_d    = rate_q;
        depth_d   = depth_q;
        run_upd_d = 1'b0;
        dec_upd_d = 1'b0;
        if (sample_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    phase_d = '0;
                    if (en_i) begin
                        rate_d  = rate_i;
                        depth_d = depth_i;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        phase_d   = phase_sum[PHASE_WIDTH-1:0];
                        run_upd_d = 1'b1;
                        // Triangle is zero at wrap, so new depth/rate enter without a step.
                        if (phase_sum[PHASE_WIDTH]) begin
                            rate_d  = rate_i;
                            depth_d = depth_i;
                        end
                    end
                end
                ST_DRAIN: begin
                    dec_upd_d = 1'b1;
                    if (out_d <= ADDR_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    assign running_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            rate_q    <= '0;
            depth_q   <= '0;
            run_upd_q <= 1'b0;
            dec_upd_q <= 1'b0;
            out_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rate_q    <= rate_d;
            depth_q   <= depth_d;
            run_upd_q <= run_upd_d;
            dec_upd_q <= dec_upd_d;
            out_q     <= out_d;
            running_q <= running_d;
        end
    end

    assign extra_delay_o = out_q;
    assign running_o     = running_q;

endmodule

// File: tb/tb_chorus_lfo.sv
// Directed bench for chorus_lfo: waveform, depth latch, hold, back-to-back, drain and reset.
module tb_chorus_lfo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid_i;
    logic        en_i;
    logic [19:0] rate_i;
    logic [9:0]  depth_i;
    logic [12:0] extra_delay_o;
    logic        running_o;

    int n_checks = 0;
    int n_errors = 0;

    chorus_lfo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid_i (sample_valid_i),
        .en_i           (en_i),
        .rate_i         (rate_i),
        .depth_i        (depth_i),
        .extra_delay_o  (extra_delay_o),
        .running_o      (running_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One strobe from a falling edge; returns on the falling edge after the output update.
    task automatic strobe();
        sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    initial begin
        int wave1 [16];
        int wave2 [8];
        for (int k = 1; k <= 7; k++) wave1[k-1] = 64 * k;
        wave1[7] = 511;
        for (int j = 1; j <= 7; j++) wave1[7+j] = 511 - 64 * j;
        wave1[15] = 0;
        for (int k = 1; k <= 7; k++) wave2[k-1] = 32 * k;
        wave2[7] = 255;

        rst_n = 1'b0;
        sample_valid_i = 1'b0;
        en_i = 1'b0;
        rate_i = '0;
        depth_i = '0;
        repeat (3) @(negedge clk);
        check("reset_out", int'(extra_delay_o), 0);
        check("reset_running", int'(running_o), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_out", int'(extra_delay_o), 0);

`ifdef LFO_SMOOTH_EN
        rate_i = 20'd65536;
        depth_i = 10'd512;
        en_i = 1'b1;
        strobe();
        check("entry_running", int'(running_o), 1);
        for (int k = 1; k <= 5; k++) begin
            strobe();
            check($sformatf("smooth_%0d", k), int'(extra_delay_o), 4 * k);
        end
        en_i = 1'b0;
        strobe();
        check("smooth_drain_entry", int'(extra_delay_o), 20);
        strobe();
        check("smooth_drain_dec", int'(extra_delay_o), 19);
`else
        rate_i = 20'd65536;
        depth_i = 10'd512;
        en_i = 1'b1;
        strobe();
        check("entry_running", int'(running_o), 1);
        check("entry_out", int'(extra_delay_o), 0);

        for (int k = 1; k <= 16; k++) begin
            if (k == 5) depth_i = 10'd256;
            strobe();
            check($sformatf("wave1_%0d", k), int'(extra_delay_o), wave1[k-1]);
        end
        for (int k = 1; k <= 8; k++) begin
            strobe();
            check($sformatf("wave2_%0d", k), int'(extra_delay_o), wave2[k-1]);
        end

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("hold_out_%0d", c), int'(extra_delay_o), 255);
        end
        check("hold_running", int'(running_o), 1);

        sample_valid_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_1", int'(extra_delay_o), 223);
        @(negedge clk);
        check("b2b_2", int'(extra_delay_o), 191);
        sample_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_3", int'(extra_delay_o), 159);

        for (int j = 4; j <= 7; j++) begin
            strobe();
            check($sformatf("wave2_tail_%0d", j), int'(extra_delay_o), 255 - 32 * j);
        end
        rate_i = 20'd307200;
        depth_i = 10'd512;
        strobe();
        check("wrap2_out", int'(extra_delay_o), 0);
        strobe();
        check("relatch_out", int'(extra_delay_o), 300);

        en_i = 1'b0;
        strobe();
        check("drain_entry_out", int'(extra_delay_o), 300);
        check("drain_entry_running", int'(running_o), 1);
        en_i = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            strobe();
            check($sformatf("drain_%0d", i), int'(extra_delay_o), 300 - i);
            if (i >= 299) check($sformatf("drain_running_%0d", i), int'(running_o), (i < 300) ? 1 : 0);
        end

        strobe();
        check("reenter_running", int'(running_o), 1);
        check("reenter_out", int'(extra_delay_o), 0);
        strobe();
        check("reenter_wave", int'(extra_delay_o), 300);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", int'(extra_delay_o), 0);
        check("async_reset_running", int'(running_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_out", int'(extra_delay_o), 0);
        check("post_reset_running", int'(running_o), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
